// File: rtl/ramp_adc_controller.sv
// Ramp ADC sequencer: steps the R2R ladder code from 0 upward and captures the code at the comparator crossing.
// Latency: the result appears one clock after the crossing pulse; worst case is 1 + STEP_CYCLES*(1+2^WIDTH) clocks from start.
// No backpressure: start is ignored while busy, and sample_valid is a one-cycle pulse. Option macro: RAMP_AVG4_EN (four-pass averaging).
module ramp_adc_controller #(
  parameter int unsigned STEP_CYCLES = 16,
  parameter int unsigned WIDTH       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             continuous,
  input  logic             capture_pulse,
  output logic [WIDTH-1:0] R2R_out,
  output logic [WIDTH-1:0] sample_data,
  output logic             sample_valid,
  output logic             overrange,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARM  = 2'd1,
    S_RAMP = 2'd2
  } state_t;

  localparam logic [15:0]      STEP_LAST = 16'(STEP_CYCLES - 1);
  localparam logic [WIDTH-1:0] CODE_MAX  = '1;
  localparam logic [WIDTH-1:0] CODE_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           r_state;
  state_t           w_state_nxt;
  logic [15:0]      r_step;
  logic [WIDTH-1:0] r_code;
  logic [WIDTH-1:0] r_sample_data;
  logic             r_sample_valid;
  logic             r_overrange;

  logic w_step_done;
  logic w_capture;
  logic w_exhaust;
  logic w_pass_done;
  logic w_pass_ovr;
  logic w_result;

  // Step timing and pass termination. A capture always wins over exhaustion,
  // and in either case the reported code is the one currently on the ladder.
  assign w_step_done = (r_step == STEP_LAST);
  assign w_capture   = (r_state == S_RAMP) && capture_pulse;
  assign w_exhaust   = (r_state == S_RAMP) && w_step_done && (r_code == CODE_MAX);
  assign w_pass_done = w_capture || w_exhaust;
  assign w_pass_ovr  = !w_capture;

`ifdef RAMP_AVG4_EN
  logic [1:0]       r_pass;
  logic [WIDTH+1:0] r_acc;
  logic             r_ovr_acc;
  logic [WIDTH+1:0] w_acc_sum;

  assign w_acc_sum = r_acc + {2'b00, r_code};
  assign w_result  = w_pass_done && (r_pass == 2'd3);

  // Accumulate the first three passes; the fourth pass reports and clears.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pass    <= 2'd0;
      r_acc     <= '0;
      r_ovr_acc <= 1'b0;
    end else if (w_pass_done) begin
      r_pass <= r_pass + 2'd1;
      if (w_result) begin
        r_acc     <= '0;
        r_ovr_acc <= 1'b0;
      end else begin
        r_acc     <= w_acc_sum;
        r_ovr_acc <= r_ovr_acc | w_pass_ovr;
      end
    end
  end
`else
  assign w_result = w_pass_done;
`endif

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode and busy output.
  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start || continuous) begin
          w_state_nxt = S_ARM;
        end
      end
      S_ARM: begin
        busy = 1'b1;
        if (w_step_done) begin
          w_state_nxt = S_RAMP;
        end
      end
      S_RAMP: begin
        busy = 1'b1;
        if (w_pass_done) begin
          // An intermediate averaging pass re-arms regardless of continuous.
          if (!w_result || continuous) begin
            w_state_nxt = S_ARM;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Step counter: restarts on every state change and at the end of each step.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_step <= 16'd0;
    end else if ((r_state == S_IDLE) || (w_state_nxt != r_state) || w_step_done) begin
      r_step <= 16'd0;
    end else begin
      r_step <= r_step + 16'd1;
    end
  end

  // Ladder code: zero outside RAMP, advances at each completed step.
  // Exhaustion leaves RAMP before the code could wrap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_code <= '0;
    end else if (w_state_nxt != S_RAMP) begin
      r_code <= '0;
    end else if ((r_state == S_RAMP) && w_step_done) begin
      r_code <= r_code + CODE_ONE;
    end
  end

  // Result registers: updated together with the one-cycle valid pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sample_data  <= '0;
      r_overrange    <= 1'b0;
      r_sample_valid <= 1'b0;
    end else begin
      r_sample_valid <= w_result;
      if (w_result) begin
`ifdef RAMP_AVG4_EN
        r_sample_data <= w_acc_sum[WIDTH+1:2];
        r_overrange   <= r_ovr_acc | w_pass_ovr;
`else
        r_sample_data <= r_code;
        r_overrange   <= w_pass_ovr;
`endif
      end
    end
  end

  assign R2R_out      = r_code;
  assign sample_data  = r_sample_data;
  assign sample_valid = r_sample_valid;
  assign overrange    = r_overrange;

endmodule

// File: tb/tb_ramp_adc_controller.sv
// Bench for ramp_adc_controller with STEP_CYCLES=4, WIDTH=8.
// Expected results are queued when a conversion is stimulated and popped on each sample_valid.
// Build with RAMP_AVG4_EN defined to exercise the four-pass averaging variant.
module tb_ramp_adc_controller;

  localparam int STEP = 4;
  localparam int W    = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic         continuous = 1'b0;
  logic         capture_pulse = 1'b0;
  logic [W-1:0] R2R_out;
  logic [W-1:0] sample_data;
  logic         sample_valid;
  logic         overrange;
  logic         busy;

  int           n_total = 0;
  int           n_bad   = 0;
  int           n_valid = 0;
  int           n_exp   = 0;
  logic [8:0]   sb_q[$];

  ramp_adc_controller #(.STEP_CYCLES(STEP), .WIDTH(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .continuous   (continuous),
    .capture_pulse(capture_pulse),
    .R2R_out      (R2R_out),
    .sample_data  (sample_data),
    .sample_valid (sample_valid),
    .overrange    (overrange),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard consumer: every valid pulse must match the oldest queued result.
  always @(negedge clk) begin
    logic [8:0] e;
    if (sample_valid) begin
      n_valid++;
      if (sb_q.size() == 0) begin
        chk_eq("spurious_valid", 32'(sample_valid), 32'd0);
      end else begin
        e = sb_q.pop_front();
        chk_eq("sb_data", 32'(sample_data), 32'(e[7:0]));
        chk_eq("sb_ovr", 32'(overrange), 32'(e[8]));
      end
    end
  end

  // Entered just after the edge that put the DUT in ARM; returns just after
  // the edge that ends the pass. cap_at: 0..255 capture at that code,
  // 256 capture on the exhaustion clock, -1 no capture.
  task automatic run_conv(input int cap_at, input bit noise, input int drop_k,
                          input bit last, input logic [8:0] exp_res);
    int code_e;
    bit done;
    done = 1'b0;
    for (int k = 0; k < 1100 && !done; k++) begin
      code_e = (k < STEP) ? 0 : (k - STEP) / STEP;
      chk_eq("ramp_code", 32'(R2R_out), 32'(code_e));
      chk_eq("ramp_busy", 32'(busy), 32'd1);
      capture_pulse = 1'b0;
      start = 1'b0;
      if (noise && k == 1) capture_pulse = 1'b1;
      if (noise && k == STEP + 6) start = 1'b1;
      if (k == drop_k) continuous = 1'b0;
      if ((cap_at >= 0 && cap_at < 256 && k >= STEP && code_e == cap_at && (k - STEP) % STEP == 1)
          || k == STEP * 257 - 1) begin
        if (cap_at >= 0) capture_pulse = 1'b1;
        if (last) begin
          sb_q.push_back(exp_res);
          n_exp++;
        end
        done = 1'b1;
      end
      tick();
    end
    capture_pulse = 1'b0;
    start = 1'b0;
    chk_eq("conv_done", 32'(done), 32'd1);
    if (last) begin
      chk_eq("res_valid", 32'(sample_valid), 32'd1);
      chk_eq("res_data", 32'(sample_data), 32'(exp_res[7:0]));
      chk_eq("res_ovr", 32'(overrange), 32'(exp_res[8]));
    end else begin
      chk_eq("mid_valid", 32'(sample_valid), 32'd0);
    end
    chk_eq("res_r2r", 32'(R2R_out), 32'd0);
    chk_eq("res_busy", 32'(busy), last ? 32'(continuous) : 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired total=%0d bad=%0d", n_total, n_bad);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) tick();
    chk_eq("rst_r2r", 32'(R2R_out), 32'd0);
    chk_eq("rst_data", 32'(sample_data), 32'd0);
    chk_eq("rst_valid", 32'(sample_valid), 32'd0);
    chk_eq("rst_ovr", 32'(overrange), 32'd0);
    chk_eq("rst_busy", 32'(busy), 32'd0);
    reset = 1'b1;
    repeat (2) tick();
    chk_eq("idle_busy", 32'(busy), 32'd0);

`ifndef RAMP_AVG4_EN
    // Capture at 0x5A, with an ignored capture in ARM and an ignored start in RAMP.
    start = 1'b1; tick(); start = 1'b0;
    run_conv(8'h5A, 1'b1, -1, 1'b1, {1'b0, 8'h5A});
    tick();
    chk_eq("pulse_single", 32'(sample_valid), 32'd0);
    chk_eq("after_busy", 32'(busy), 32'd0);
    repeat (3) tick();
    chk_eq("start_not_queued", 32'(busy), 32'd0);

    // Ramp exhaustion with no crossing.
    start = 1'b1; tick(); start = 1'b0;
    run_conv(-1, 1'b0, -1, 1'b1, {1'b1, 8'hFF});
    tick();

    // Crossing on the exhaustion clock wins.
    start = 1'b1; tick(); start = 1'b0;
    run_conv(256, 1'b0, -1, 1'b1, {1'b0, 8'hFF});
    tick();

    // Continuous mode: two conversions, continuous dropped mid-second.
    continuous = 1'b1; tick();
    run_conv(8'h10, 1'b0, -1, 1'b1, {1'b0, 8'h10});
    run_conv(8'h20, 1'b0, 20, 1'b1, {1'b0, 8'h20});
    tick();
    chk_eq("cont_stop_busy", 32'(busy), 32'd0);
    chk_eq("cont_stop_valid", 32'(sample_valid), 32'd0);

    // Reset mid-RAMP.
    start = 1'b1; tick(); start = 1'b0;
    repeat (20) tick();
    chk_eq("pre_rst_code", 32'(R2R_out), 32'd4);
    reset = 1'b0;
    #1;
    chk_eq("mid_rst_r2r", 32'(R2R_out), 32'd0);
    chk_eq("mid_rst_data", 32'(sample_data), 32'd0);
    chk_eq("mid_rst_busy", 32'(busy), 32'd0);
    chk_eq("mid_rst_ovr", 32'(overrange), 32'd0);
    repeat (2) tick();
    reset = 1'b1;
    repeat (3) tick();
    chk_eq("post_rst_busy", 32'(busy), 32'd0);
`else
    // Four averaged passes: (0x10+0x11+0x12+0x13)>>2 = 0x11.
    start = 1'b1; tick(); start = 1'b0;
    run_conv(8'h10, 1'b0, -1, 1'b0, 9'h000);
    run_conv(8'h11, 1'b0, -1, 1'b0, 9'h000);
    run_conv(8'h12, 1'b0, -1, 1'b0, 9'h000);
    run_conv(8'h13, 1'b0, -1, 1'b1, {1'b0, 8'h11});
    tick();
    chk_eq("avg_busy", 32'(busy), 32'd0);
    chk_eq("avg_single", 32'(sample_valid), 32'd0);
`endif

    repeat (4) tick();
    chk_eq("sb_drained", 32'(sb_q.size()), 32'd0);
    chk_eq("valid_count", 32'(n_valid), 32'(n_exp));
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
